// File: rtl/countdown_ctrl.sv
// Seconds countdown controller: prescaler tick gated by an IDLE/RUN/PAUSE/DONE state machine.
// Optional macro AUTO_RELOAD_EN: reload the count on expiry instead of entering DONE.
module countdown_ctrl #(
   parameter int DIV = 48000000,
   parameter int CW  = 32,
   parameter int VW  = 16
) (
   input  logic          clk_48MHZ,
   input  logic          rst,
   input  logic          start,
   input  logic          pause,
   input  logic          clear,
   input  logic [VW-1:0] load_val,
   output logic [VW-1:0] sec_left,
   output logic          tick_1HZ,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   localparam logic [CW-1:0] LP_LAST = CW'(DIV - 1);
   localparam logic [VW-1:0] LP_ONE  = VW'(1);

   state_t        r_state;
   logic [CW-1:0] r_presc;
   logic [VW-1:0] r_sec;
   logic          r_tick;
   logic          r_busy;
   logic          r_done;
`ifdef AUTO_RELOAD_EN
   logic [VW-1:0] r_reload;
`endif

   logic w_start_ok;
   logic w_tick_due;

   assign w_start_ok = start && (load_val != '0);
   assign w_tick_due = (r_presc == LP_LAST);

   always_ff @(posedge clk_48MHZ) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_presc  <= '0;
         r_sec    <= '0;
         r_tick   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef AUTO_RELOAD_EN
         r_reload <= '0;
`endif
      end else begin
         r_tick <= 1'b0;
`ifdef AUTO_RELOAD_EN
         // done is only a single-cycle pulse in reload mode
         r_done <= 1'b0;
`endif
         if (clear) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_sec   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE, S_DONE: begin
                  if (w_start_ok) begin
                     r_state <= S_RUN;
                     r_sec   <= load_val;
                     r_presc <= '0;
                     r_busy  <= 1'b1;
                     r_done  <= 1'b0;
`ifdef AUTO_RELOAD_EN
                     r_reload <= load_val;
`endif
                  end
               end
               S_RUN: begin
                  // pause freezes the prescaler even when a tick is due
                  if (pause) begin
                     r_state <= S_PAUSE;
                  end else if (w_tick_due) begin
                     r_presc <= '0;
                     r_tick  <= 1'b1;
                     if (r_sec == LP_ONE) begin
`ifdef AUTO_RELOAD_EN
                        r_sec  <= r_reload;
                        r_done <= 1'b1;
`else
                        r_sec   <= '0;
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                     end else if (r_sec != '0) begin
                        r_sec <= r_sec - LP_ONE;
                     end
                  end else begin
                     r_presc <= r_presc + 1'b1;
                  end
               end
               S_PAUSE: begin
                  if (!pause && start) begin
                     r_state <= S_RUN;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign sec_left = r_sec;
   assign tick_1HZ = r_tick;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with DIV=4; expected ticks queued as a scoreboard.
module tb_countdown_ctrl;

   localparam int DIV = 4;
   localparam int CW  = 8;
   localparam int VW  = 16;

   logic          clk_48MHZ = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic          clear = 1'b0;
   logic [VW-1:0] load_val = '0;
   logic [VW-1:0] sec_left;
   logic          tick_1HZ;
   logic          busy;
   logic          done;

   countdown_ctrl #(.DIV(DIV), .CW(CW), .VW(VW)) dut (
      .clk_48MHZ(clk_48MHZ),
      .rst(rst),
      .start(start),
      .pause(pause),
      .clear(clear),
      .load_val(load_val),
      .sec_left(sec_left),
      .tick_1HZ(tick_1HZ),
      .busy(busy),
      .done(done)
   );

   always #5 clk_48MHZ = ~clk_48MHZ;

   typedef struct {
      int          cyc;
      logic [15:0] sec;
   } tick_t;

   tick_t q[$];
   int total = 0;
   int bad = 0;
   int cyc_n = 0;
   int s;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // one clock: outputs sampled 1 time unit after the edge
   task automatic cyc();
      @(posedge clk_48MHZ);
      #1;
      cyc_n++;
      $display("cycle %0d: sec_left=%0d tick=%0b busy=%0b done=%0b", cyc_n, sec_left, tick_1HZ, busy, done);
   endtask

   task automatic push_ticks(input int start_cyc, input int n, input int first_sec);
      for (int k = 1; k <= n; k++) begin
         tick_t e;
         e.cyc = start_cyc + k * DIV;
         e.sec = 16'(first_sec - k);
         q.push_back(e);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         if (tick_1HZ === 1'b1) begin
            if (q.size() == 0) begin
               chk("spurious_tick", 32'(cyc_n), 32'(0));
            end else begin
               tick_t e;
               e = q.pop_front();
               chk("tick_cycle", 32'(cyc_n), 32'(e.cyc));
               chk("tick_sec", 32'(sec_left), 32'(e.sec));
            end
         end else if (q.size() != 0 && q[0].cyc <= cyc_n) begin
            tick_t e;
            e = q.pop_front();
            chk("missed_tick", 32'(cyc_n + 1000), 32'(e.cyc));
         end
      end
   endtask

   task automatic chk_outs(input string tag, input int e_sec, input logic e_busy, input logic e_done);
      chk({tag, "_sec"}, 32'(sec_left), 32'(e_sec));
      chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
      chk({tag, "_done"}, 32'(done), 32'(e_done));
   endtask

   initial begin
      // 1: reset, then idle for 20 cycles
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      chk_outs("reset", 0, 1'b0, 1'b0);
      chk("reset_tick", 32'(tick_1HZ), 32'(0));
      run(20);
      chk_outs("idle20", 0, 1'b0, 1'b0);

`ifdef AUTO_RELOAD_EN
      // 6: reload mode, load 2 -> 2,1,2,1 with done pulse every 8 cycles
      load_val = 16'd2;
      start = 1'b1;
      cyc();
      start = 1'b0;
      s = cyc_n;
      chk_outs("ar_start", 2, 1'b1, 1'b0);
      for (int k = 1; k <= 24; k++) begin
         tick_t e;
         e.cyc = s + k * DIV;
         e.sec = ((k % 2) == 1) ? 16'd1 : 16'd2;
         if ((k * DIV) <= 24) q.push_back(e);
      end
      for (int k = 1; k <= 24; k++) begin
         run(1);
         chk("ar_done", 32'(done), 32'((k % 8) == 0));
         chk("ar_busy", 32'(busy), 32'(1));
      end
      chk("ar_queue_empty", 32'(q.size()), 32'(0));
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      chk_outs("ar_clear", 0, 1'b0, 1'b0);
      run(10);
      chk_outs("ar_idle", 0, 1'b0, 1'b0);
`else
      // 2: load 3, count to DONE after 12 cycles, then hold
      load_val = 16'd3;
      start = 1'b1;
      cyc();
      start = 1'b0;
      s = cyc_n;
      chk_outs("s2_start", 3, 1'b1, 1'b0);
      push_ticks(s, 3, 3);
      run(11);
      chk_outs("s2_pre_done", 1, 1'b1, 1'b0);
      run(1);
      chk_outs("s2_done", 0, 1'b0, 1'b1);
      chk("s2_queue_empty", 32'(q.size()), 32'(0));
      run(6);
      chk_outs("s2_hold", 0, 1'b0, 1'b1);

      // 3: load 5, pause over the due 2nd tick, resume, complete
      load_val = 16'd5;
      start = 1'b1;
      cyc();
      start = 1'b0;
      s = cyc_n;
      chk_outs("s3_start", 5, 1'b1, 1'b0);
      push_ticks(s, 1, 5);
      run(7);
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         run(1);
         chk("s3_paused_sec", 32'(sec_left), 32'(4));
      end
      chk_outs("s3_paused", 4, 1'b1, 1'b0);
      pause = 1'b0;
      start = 1'b1;
      run(1);
      start = 1'b0;
      chk("s3_resume_sec", 32'(sec_left), 32'(4));
      push_ticks(cyc_n - 3, 4, 4);
      run(13);
      chk_outs("s3_done", 0, 1'b0, 1'b1);
      chk("s3_queue_empty", 32'(q.size()), 32'(0));

      // 4: clear beats start and pause mid-RUN; zero load ignored
      load_val = 16'd2;
      start = 1'b1;
      cyc();
      start = 1'b0;
      s = cyc_n;
      push_ticks(s, 1, 2);
      run(5);
      chk_outs("s4_mid", 1, 1'b1, 1'b0);
      clear = 1'b1;
      start = 1'b1;
      pause = 1'b1;
      cyc();
      clear = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      chk_outs("s4_clear", 0, 1'b0, 1'b0);
      chk("s4_clear_tick", 32'(tick_1HZ), 32'(0));
      run(10);
      chk_outs("s4_idle", 0, 1'b0, 1'b0);
      load_val = 16'd0;
      start = 1'b1;
      run(1);
      start = 1'b0;
      chk_outs("s4_zero_load", 0, 1'b0, 1'b0);
      run(8);
      chk_outs("s4_zero_idle", 0, 1'b0, 1'b0);

      // 5: DONE -> restart with load 1 -> DONE after 4; then rst mid-RUN
      load_val = 16'd1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      push_ticks(cyc_n, 1, 1);
      run(4);
      chk_outs("s5_done1", 0, 1'b0, 1'b1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk_outs("s5_restart", 1, 1'b1, 1'b0);
      push_ticks(cyc_n, 1, 1);
      run(3);
      chk_outs("s5_pre_done", 1, 1'b1, 1'b0);
      run(1);
      chk_outs("s5_done2", 0, 1'b0, 1'b1);
      load_val = 16'd3;
      start = 1'b1;
      cyc();
      start = 1'b0;
      push_ticks(cyc_n, 3, 3);
      run(2);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      q.delete();
      chk_outs("s5_rst", 0, 1'b0, 1'b0);
      chk("s5_rst_tick", 32'(tick_1HZ), 32'(0));
      run(10);
      chk_outs("s5_after_rst", 0, 1'b0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
